// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
// Holds the FSM state encoding and the byte-merge helper used by the storage array.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DEPTH_DEF   = 256;
    localparam logic [31:0] BASE_DEF    = 32'h1001_0000;
    localparam int          LATENCY_DEF = 2;

    // Replace only the lanes whose enable bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enabled write, combinational read and per-word valid bits.
// Only the valid bits are cleared by reset; an invalid word reads as zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wbe,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0]      mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [31:0]      old_word_s;
    logic             wr_s;

    // Lanes not enabled on a first write must read back as zero, not stale array content.
    always_comb begin
        old_word_s = valid_r[widx] ? mem_r[widx] : 32'h0000_0000;
        wr_s       = wen && (wbe != 4'b0000);
        rdata      = valid_r[ridx] ? mem_r[ridx] : 32'h0000_0000;
    end

    // Data array write; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[widx] <= merge_bytes(old_word_s, wdata, wbe);
        end
    end

    // Valid bit per word, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (wr_s) begin
            valid_r[widx] <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states.
// Requests are checked for range/alignment; stores commit on the edge entering RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH   = DEPTH_DEF,
    parameter logic [31:0] BASE    = BASE_DEF,
    parameter int          LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH);
    localparam logic [2:0]  LAT_LOAD   = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
    localparam logic        NO_WAIT    = (LATENCY == 0);

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [31:0] addr_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic [31:0]   cur_addr_s;
    logic          cur_we_s;
    logic [31:0]   cur_wdata_s;
    logic [3:0]    cur_be_s;
    logic [31:0]   off_s;
    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic          enter_resp_s;
    logic          wen_s;
    logic [31:0]   rd_s;
    logic [31:0]   rsp_data_s;

    // With zero wait states the commit happens on the acceptance edge, so use the live request.
    always_comb begin
        if (state_r == IDLE) begin
            cur_addr_s  = req_addr;
            cur_we_s    = req_we;
            cur_wdata_s = req_wdata;
            cur_be_s    = req_be;
        end else begin
            cur_addr_s  = addr_r;
            cur_we_s    = we_r;
            cur_wdata_s = wdata_r;
            cur_be_s    = be_r;
        end
        off_s        = cur_addr_s - BASE;
        in_range_s   = (cur_addr_s >= BASE) && (off_s < SPAN_BYTES) && (cur_addr_s[1:0] == 2'b00);
        idx_s        = AW'(off_s >> 2);
        enter_resp_s = ((state_r == IDLE) && req_valid && NO_WAIT) ||
                       ((state_r == BUSY) && (cnt_r == 3'd0));
        wen_s        = enter_resp_s && cur_we_s && in_range_s;
        rsp_data_s   = (in_range_s && !cur_we_s) ? rd_s : 32'h0000_0000;
    end

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen_s),
        .widx  (idx_s),
        .wdata (cur_wdata_s),
        .wbe   (cur_be_s),
        .ridx  (idx_s),
        .rdata (rd_s)
    );

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            addr_r      <= 32'h0000_0000;
            we_r        <= 1'b0;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'b0000;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_r      <= req_addr;
                        we_r        <= req_we;
                        wdata_r     <= req_wdata;
                        be_r        <= req_be;
                        req_ready_r <= 1'b0;
                        if (NO_WAIT) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= rsp_data_s;
                            rsp_err_r   <= !in_range_s;
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= LAT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r == 3'd0) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= rsp_data_s;
                        rsp_err_r   <= !in_range_s;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 3'd0;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: two responders (2 and 0 wait states) against a word-array model.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    logic [31:0] mdl [2][256];
    int total;
    int bad;

    dmem_responder #(.DEPTH(256), .BASE(BASE), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(256), .BASE(BASE), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 256; i++)
                mdl[u][i] = 32'h0;
    endtask

    // One full transaction; caller is at a negedge with unit u idle.
    // Handshake edge counted as edge number (1+LATENCY) after acceptance.
    task automatic txn(input int u, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold);
        int exp_lat;
        int waited;
        logic ok;
        int idx;
        logic [31:0] exp_d;
        logic exp_e;
        exp_lat = (u == 0) ? 3 : 1;
        ok  = (addr >= BASE) && (addr < BASE + 32'd1024) && (addr[1:0] == 2'b00);
        idx = ok ? int'((addr - BASE) >> 2) : 0;
        exp_d = (ok && !we) ? mdl[u][idx] : 32'h0;
        exp_e = !ok;

        total++;
        if (req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready u=%0d got=%b want=1", u, req_ready[u]);
        end
        req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr;
        req_wdata[u] = wdata; req_be[u] = be;
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = 1'b0;
        waited = 1;
        while (rsp_valid[u] !== 1'b1 && waited < 20) begin
            rsp_ready[u] = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        total++;
        if (waited !== exp_lat) begin
            bad++;
            $display("FAIL latency u=%0d addr=%h got=%0d want=%0d", u, addr, waited, exp_lat);
        end
        total++;
        if (rsp_rdata[u] !== exp_d || rsp_err[u] !== exp_e) begin
            bad++;
            $display("FAIL response u=%0d addr=%h we=%b got=%h/%b want=%h/%b",
                     u, addr, we, rsp_rdata[u], rsp_err[u], exp_d, exp_e);
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready[u] = 1'b0;
            req_valid[u] = 1'b1;
            req_addr[u]  = BASE + 32'd64;
            req_we[u]    = 1'b1;
            @(posedge clk);
            @(negedge clk);
            total++;
            if (rsp_valid[u] !== 1'b1 || rsp_rdata[u] !== exp_d || rsp_err[u] !== exp_e || req_ready[u] !== 1'b0) begin
                bad++;
                $display("FAIL hold%0d u=%0d got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                         h, u, rsp_valid[u], rsp_rdata[u], rsp_err[u], req_ready[u], exp_d, exp_e);
            end
        end
        req_valid[u] = 1'b0;
        req_we[u]    = 1'b0;
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        total++;
        if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
            bad++;
            $display("FAIL after_hs u=%0d got v=%b rdy=%b want v=0 rdy=1", u, rsp_valid[u], req_ready[u]);
        end
        if (ok && we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[u][idx][8*b +: 8] = wdata[8*b +: 8];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        for (int u = 0; u < 2; u++) begin
            total++;
            if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'h0 || rsp_err[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state u=%0d got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                         u, req_ready[u], rsp_valid[u], rsp_rdata[u], rsp_err[u]);
            end
        end
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        txn(0, 1'b1, 32'h1001_0004, 32'hCAFE_F00D, 4'hF, 0);
        txn(0, 1'b0, 32'h1001_0004, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h1001_0004, 32'h0000_00AA, 4'b0001, 0);
        txn(0, 1'b0, 32'h1001_0004, 32'h0, 4'hF, 0);
        total++;
        if (mdl[0][1] !== 32'hCAFE_F0AA) begin
            bad++;
            $display("FAIL model_merge got=%h want=cafef0aa", mdl[0][1]);
        end
    endtask

    task automatic test_errors();
        txn(0, 1'b0, 32'h1001_0402, 32'h0, 4'hF, 0);
        txn(0, 1'b0, 32'h1001_0400, 32'h0, 4'hF, 0);
        txn(0, 1'b1, 32'h1001_0400, 32'h1234_5678, 4'hF, 0);
        txn(0, 1'b1, 32'h1001_0006, 32'h1234_5678, 4'hF, 0);
        txn(0, 1'b1, 32'h1000_FFFC, 32'h1234_5678, 4'hF, 0);
        txn(0, 1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'b0000, 0);
        txn(0, 1'b0, 32'h1001_0004, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h1001_0000, 32'h0, 4'h0, 0);
    endtask

    task automatic test_stall();
        txn(0, 1'b1, 32'h1001_0008, 32'h5A5A_1234, 4'hF, 0);
        txn(0, 1'b0, 32'h1001_0008, 32'h0, 4'h0, 5);
        txn(1, 1'b1, 32'h1001_03FC, 32'h8765_4321, 4'hF, 0);
        txn(1, 1'b0, 32'h1001_03FC, 32'h0, 4'h0, 3);
    endtask

    task automatic test_reset_busy();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h1001_0010;
        req_wdata[0] = 32'hDEAD_BEEF; req_be[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                     req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        end
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 32'h1001_0010, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h1001_0004, 32'h0, 4'h0, 0);
    endtask

    task automatic test_latency0();
        txn(1, 1'b1, 32'h1001_0004, 32'hCAFE_F00D, 4'hF, 0);
        txn(1, 1'b0, 32'h1001_0004, 32'h0, 4'h0, 0);
        txn(1, 1'b0, 32'h1001_0402, 32'h0, 4'h0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0, 1, 2, 3: a = BASE + (32'($urandom_range(0, 15)) << 2);
                4: a = BASE + 32'h3FC;
                5: a = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
                default: a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'd1024 + (32'($urandom_range(0, 7)) << 2);
            endcase
            txn(n % 2, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = 32'h0;
            req_wdata[u] = 32'h0; req_be[u] = 4'h0; rsp_ready[u] = 1'b0;
        end
        test_reset();
        test_basic();
        test_errors();
        test_stall();
        test_reset_busy();
        test_latency0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL expose parameters: DEPTH, 256, number of 32-bit words stored.
REQ-002 The block SHALL expose parameter BASE, 32'h10010000, byte address of word 0 (data segment).
REQ-003 The block SHALL expose parameter LATENCY, 2, wait-state cycles per access (legal 0..7).
REQ-004 The block SHALL have the following ports:
  clk  input  1  single clock, all state on rising edge
  rst  input  1  asynchronous, active-low reset
  req_valid  input  1  initiator presents a request
  req_ready  output  1  responder can accept a request
  req_we  input  1  1 = store, 0 = load
  req_addr  input  32  byte address
  req_wdata  input  32  store data
  req_be  input  4  byte enables for store; bit i enables bits 8i+7:8i
  rsp_valid  output  1  response available
  rsp_ready  input  1  initiator accepts response
  rsp_rdata  output  32  load data
  rsp_err  output  1  access fault
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY, RESP; only one request SHALL be outstanding.
REQ-007 req_ready SHALL be 1 only in IDLE; acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1.
REQ-008 On acceptance, addr, we, wdata and be SHALL be registered; the FSM SHALL go to BUSY if LATENCY>0, else to RESP.
REQ-009 BUSY SHALL last exactly LATENCY cycles via a down-counter loaded with LATENCY-1; at count 0 the FSM SHALL go to RESP.
REQ-010 rsp_valid SHALL rise exactly 1+LATENCY cycles after the acceptance edge.
REQ-011 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until a rising edge with rsp_ready=1, after which the FSM SHALL return to IDLE.
REQ-012 A request SHALL be in range iff BASE <= addr < BASE+4*DEPTH and addr[1:0]==2'b00; word index = (addr-BASE)>>2.
REQ-013 An in-range store SHALL update only the enabled bytes, committed on the edge entering RESP; rsp_rdata SHALL be 0, rsp_err 0.
REQ-014 A store with req_be=4'b0000 SHALL complete normally without modifying storage.
REQ-015 An in-range load SHALL return the full word as stored at the edge entering RESP; req_be SHALL be ignored.
REQ-016 A word never written since reset SHALL read as 32'h00000000 (per-word valid bit).
REQ-017 An out-of-range or misaligned request SHALL not modify storage, SHALL return rsp_err=1, rsp_rdata=0, with the same latency.
REQ-018 rsp_ready asserted outside RESP SHALL be ignored; req_valid while not IDLE SHALL be ignored (not queued).
REQ-019 The earliest next acceptance SHALL be the edge after the response handshake edge.

Reset
REQ-020 Asserting rst at any time SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, all valid bits=0.
REQ-021 A request in BUSY or RESP at reset SHALL be discarded; a store not yet committed SHALL have no effect.
REQ-022 The data array SHALL not be reset; only the valid bits SHALL be cleared.

Structure
REQ-023 Package dmem_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and default constants for DEPTH, BASE, LATENCY.
REQ-024 The storage SHALL be a sub-module dmem_array (byte-enabled write port, combinational read, valid bits, async active-low clear of valid bits).

Verification
REQ-025 Store 32'hCAFEF00D to 32'h10010004, be=4'hF, LATENCY=2, rsp_ready=1 -> rsp_valid rises 3 cycles after acceptance, rsp_err=0; load same address -> rsp_rdata=32'hCAFEF00D.
REQ-026 Store 32'h000000AA to 32'h10010004 with be=4'b0001 after REQ-025 -> load returns 32'hCAFEF0AA.
REQ-027 Load 32'h10010402 (misaligned) and 32'h10010400 (DEPTH=256, out of range) -> rsp_err=1, rsp_rdata=0, storage unchanged.
REQ-028 Load 32'h10010008 with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata stable all 5 cycles, req_ready=0, a concurrent req_valid ignored.
REQ-029 Store to 32'h10010010, assert rst during BUSY -> outputs at reset values immediately; subsequent load of 32'h10010010 returns 0.
REQ-030 Repeat REQ-025 with LATENCY=0 -> rsp_valid rises 1 cycle after acceptance.
